// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-lane helper for the SRAM slave.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2
  } state_e;

  // Little-endian byte lanes touched by a transfer; illegal sizes touch none.
  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] sz);
    case (sz)
      HSIZE_BYTE: lane_mask = 4'b0001 << a;
      HSIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_mask = 4'b1111;
      default:    lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahbl_sram_mem.sv
// DEPTH x 32 synchronous RAM, one read and one write port, per-byte write enables.
module ahbl_sram_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    wbe_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  // One narrow array per byte lane so each maps onto its own block RAM slice.
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk_i) begin
      if (we_i && wbe_i[b]) mem[waddr_i] <= wdata_i[8*b +: 8];
      if (re_i)             rdata_o[8*b +: 8] <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite responder fronting a byte-writable SRAM: wait states, ERROR responses, RAW forwarding.
module ahbl_sram_slave
  import ahbl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ahbl_hsel_i,
  input  logic [ADDR_W-1:0] ahbl_haddr_i,
  input  logic [1:0]        ahbl_htrans_i,
  input  logic              ahbl_hwrite_i,
  input  logic [2:0]        ahbl_hsize_i,
  input  logic              ahbl_hready_i,
  input  logic [31:0]       ahbl_hwdata_i,
  output logic              ahbl_hreadyout_o,
  output logic              ahbl_hresp_o,
  output logic [31:0]       ahbl_hrdata_o
);

  localparam int         AW    = $clog2(DEPTH);
  localparam logic [3:0] WS_LD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] a_addr_q;
  logic          a_write_q;
  logic [3:0]    a_mask_q;
  logic [3:0]    fwd_be_q;
  logic [31:0]   fwd_data_q;
  logic [31:0]   hrdata_q;

  logic          in_slot, accept, illegal, legal_acc, commit, hazard, rd_done;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_mask;
  logic [31:0]   ram_rdata, merged;

  // Only states whose data phase is completing can take a new address phase.
  assign in_slot = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept  = in_slot && ahbl_hsel_i && ahbl_hready_i &&
                   (ahbl_htrans_i == HTRANS_NONSEQ || ahbl_htrans_i == HTRANS_SEQ);

  assign req_addr = ahbl_haddr_i[AW+1:2];
  assign req_mask = lane_mask(ahbl_haddr_i[1:0], ahbl_hsize_i);
  assign illegal  = ((ahbl_haddr_i >> (AW + 2)) != '0) ||
                    (ahbl_hsize_i > HSIZE_WORD) ||
                    (ahbl_hsize_i == HSIZE_HALF && ahbl_haddr_i[0]) ||
                    (ahbl_hsize_i == HSIZE_WORD && ahbl_haddr_i[1:0] != 2'b00);

  assign legal_acc = accept && !illegal;
  assign commit    = (state_q == ST_DATA) && a_write_q;
  assign rd_done   = (state_q == ST_DATA) && !a_write_q;
  // RAM reads the pre-write word when a read lands on the committing word; patch it later.
  assign hazard    = legal_acc && !ahbl_hwrite_i && commit && (req_addr == a_addr_q);

  ahbl_sram_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (clk_i),
    .we_i    (commit),
    .waddr_i (a_addr_q),
    .wbe_i   (a_mask_q),
    .wdata_i (ahbl_hwdata_i),
    .re_i    (legal_acc && !ahbl_hwrite_i),
    .raddr_i (req_addr),
    .rdata_o (ram_rdata)
  );

  for (genvar b = 0; b < 4; b++) begin : g_merge
    assign merged[8*b +: 8] = fwd_be_q[b] ? fwd_data_q[8*b +: 8] : ram_rdata[8*b +: 8];
  end

  assign ahbl_hrdata_o = rd_done ? merged : hrdata_q;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    ahbl_hreadyout_o = 1'b1;
    ahbl_hresp_o     = HRESP_OKAY;
    case (state_q)
      ST_WAIT: begin
        ahbl_hreadyout_o = 1'b0;
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: begin
        ahbl_hreadyout_o = 1'b0;
        ahbl_hresp_o     = HRESP_ERROR;
        state_d          = ST_ERR2;
      end
      ST_ERR2: ahbl_hresp_o = HRESP_ERROR;
      default: ;
    endcase
    if (accept) begin
      if (illegal) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = ST_WAIT;
        cnt_d   = WS_LD;
      end else begin
        state_d = ST_DATA;
      end
    end else if (in_slot) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      a_addr_q   <= '0;
      a_write_q  <= 1'b0;
      a_mask_q   <= 4'd0;
      fwd_be_q   <= 4'd0;
      fwd_data_q <= 32'd0;
      hrdata_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_addr_q   <= req_addr;
        a_write_q  <= ahbl_hwrite_i;
        a_mask_q   <= req_mask;
        fwd_be_q   <= hazard ? a_mask_q : 4'd0;
        fwd_data_q <= ahbl_hwdata_i;
      end
      if (rd_done) hrdata_q <= merged;
    end
  end

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench: one zero-wait and one three-wait instance on a shared stimulus bus.
module tb_ahbl_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        use3 = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [31:0] hwdata = '0;

  logic        ho0, hr0, ho3, hr3;
  logic [31:0] hd0, hd3;
  logic        hro, hresp;
  logic [31:0] hrd;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign hro   = use3 ? ho3 : ho0;
  assign hresp = use3 ? hr3 : hr0;
  assign hrd   = use3 ? hd3 : hd0;

  ahbl_sram_slave #(.ADDR_W(32), .DEPTH(1024), .WAIT_STATES(0)) u0 (
    .clk_i(clk), .rst_i(rst), .ahbl_hsel_i(hsel && !use3), .ahbl_haddr_i(haddr),
    .ahbl_htrans_i(htrans), .ahbl_hwrite_i(hwrite), .ahbl_hsize_i(hsize),
    .ahbl_hready_i(ho0), .ahbl_hwdata_i(hwdata),
    .ahbl_hreadyout_o(ho0), .ahbl_hresp_o(hr0), .ahbl_hrdata_o(hd0));

  ahbl_sram_slave #(.ADDR_W(32), .DEPTH(1024), .WAIT_STATES(3)) u3 (
    .clk_i(clk), .rst_i(rst), .ahbl_hsel_i(hsel && use3), .ahbl_haddr_i(haddr),
    .ahbl_htrans_i(htrans), .ahbl_hwrite_i(hwrite), .ahbl_hsize_i(hsize),
    .ahbl_hready_i(ho3), .ahbl_hwdata_i(hwdata),
    .ahbl_hreadyout_o(ho3), .ahbl_hresp_o(hr3), .ahbl_hrdata_o(hd3));

  // Single non-pipelined transfer; reports stall count and hresp seen across the data phase.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int lows,
                      output logic r_and, output logic r_or);
    lows = 0; r_and = 1'b1; r_or = 1'b0; rd = '0;
    hsel = 1'b1; htrans = 2'd2; hwrite = w; haddr = a; hsize = sz;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = wd;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      r_and = r_and & hresp;
      r_or  = r_or | hresp;
      if (hro) begin rd = hrd; break; end
      lows++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // Write address phase immediately followed by a read address phase.
  task automatic pipe(input logic [31:0] wa, input logic [2:0] wsz, input logic [31:0] wd,
                      input logic [31:0] ra, output int l1, output int l2,
                      output logic [31:0] rd, output logic rsp);
    l1 = 0; l2 = 0; rsp = 1'b0; rd = '0;
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = wa; hsize = wsz;
    @(posedge clk); #1;
    hwrite = 1'b0; haddr = ra; hsize = 3'd2; hwdata = wd;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rsp = rsp | hresp;
      if (hro) break;
      l1++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rsp = rsp | hresp;
      if (hro) begin rd = hrd; break; end
      l2++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (ho0 !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout0 got %b want 1", ho0); end
    n_chk++; if (hr0 !== 1'b0) begin n_fail++; $display("FAIL reset_hresp0 got %b want 0", hr0); end
    n_chk++; if (hd0 !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata0 got %h want 0", hd0); end
    n_chk++; if (ho3 !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout3 got %b want 1", ho3); end
    n_chk++; if (hd3 !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata3 got %h want 0", hd3); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd; int lows; logic ra, ro;
    use3 = 1'b0;
    xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, lows, ra, ro);
    n_chk++; if (lows != 0 || ro !== 1'b0) begin n_fail++; $display("FAIL word_wr lows=%0d resp=%b want 0/0", lows, ro); end
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lows, ra, ro);
    n_chk++; if (lows != 0 || ro !== 1'b0) begin n_fail++; $display("FAIL word_rd_rsp lows=%0d resp=%b want 0/0", lows, ro); end
    n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_rd got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; int lows; logic ra, ro;
    use3 = 1'b0;
    xfer(1'b1, 32'h13, 3'd0, 32'hAA000000, rd, lows, ra, ro);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lows, ra, ro);
    n_chk++; if (rd !== 32'hAAADBEEF) begin n_fail++; $display("FAIL byte_wr got %h want aaadbeef", rd); end
    xfer(1'b1, 32'h10, 3'd1, 32'h00001234, rd, lows, ra, ro);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lows, ra, ro);
    n_chk++; if (rd !== 32'hAAAD1234) begin n_fail++; $display("FAIL half_wr got %h want aaad1234", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; int lows; logic ra, ro;
    logic        ew [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] ea [4] = '{32'h02, 32'h10, 32'h1000, 32'h11};
    logic [2:0]  es [4] = '{3'd2, 3'd3, 3'd2, 3'd1};
    use3 = 1'b0;
    xfer(1'b1, 32'h0, 3'd2, 32'h11111111, rd, lows, ra, ro);
    for (int i = 0; i < 4; i++) begin
      xfer(ew[i], ea[i], es[i], 32'hFFFFFFFF, rd, lows, ra, ro);
      n_chk++;
      if (lows != 1 || ra !== 1'b1) begin
        n_fail++; $display("FAIL err_rsp[%0d] lows=%0d resp_all=%b want 1/1", i, lows, ra);
      end
      if (i == 0) begin
        n_chk++; if (rd !== 32'hAAAD1234) begin n_fail++; $display("FAIL err_hold got %h want aaad1234", rd); end
      end
    end
    xfer(1'b0, 32'h0, 3'd2, 32'h0, rd, lows, ra, ro);
    n_chk++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL err_nowr0 got %h want 11111111", rd); end
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lows, ra, ro);
    n_chk++; if (rd !== 32'hAAAD1234) begin n_fail++; $display("FAIL err_nowr10 got %h want aaad1234", rd); end
  endtask

  task automatic test_idle_busy();
    logic [31:0] rd; int lows; logic ra, ro;
    logic       vs [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] vt [3] = '{2'd0, 2'd1, 2'd2};
    use3 = 1'b0;
    hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2; hwdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      hsel = vs[i]; htrans = vt[i];
      @(negedge clk);
      n_chk++;
      if (hro !== 1'b1 || hresp !== 1'b0) begin
        n_fail++; $display("FAIL idle_rsp[%0d] ready=%b resp=%b want 1/0", i, hro, hresp);
      end
      @(posedge clk); #1;
    end
    hsel = 1'b0; htrans = 2'd0;
    @(posedge clk); #1;
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, lows, ra, ro);
    n_chk++; if (rd !== 32'hAAAD1234) begin n_fail++; $display("FAIL idle_nowr got %h want aaad1234", rd); end
  endtask

  task automatic test_back_to_back();
    int l1, l2; logic [31:0] rd; logic rsp;
    use3 = 1'b1;
    pipe(32'h20, 3'd2, 32'hCAFEF00D, 32'h20, l1, l2, rd, rsp);
    n_chk++; if (l1 != 3 || l2 != 3 || rsp !== 1'b0) begin n_fail++; $display("FAIL b2b3_lat l1=%0d l2=%0d resp=%b want 3/3/0", l1, l2, rsp); end
    n_chk++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b3_fwd got %h want cafef00d", rd); end
    pipe(32'h21, 3'd0, 32'h00005500, 32'h20, l1, l2, rd, rsp);
    n_chk++; if (rd !== 32'hCAFE550D) begin n_fail++; $display("FAIL b2b3_merge got %h want cafe550d", rd); end
    use3 = 1'b0;
    pipe(32'h30, 3'd2, 32'h01020304, 32'h30, l1, l2, rd, rsp);
    n_chk++; if (l1 != 0 || l2 != 0) begin n_fail++; $display("FAIL b2b0_lat l1=%0d l2=%0d want 0/0", l1, l2); end
    n_chk++; if (rd !== 32'h01020304) begin n_fail++; $display("FAIL b2b0_fwd got %h want 01020304", rd); end
    pipe(32'h32, 3'd1, 32'hBEEF0000, 32'h30, l1, l2, rd, rsp);
    n_chk++; if (rd !== 32'hBEEF0304) begin n_fail++; $display("FAIL b2b0_merge got %h want beef0304", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lows; logic ra, ro;
    use3 = 1'b1;
    xfer(1'b1, 32'h40, 3'd2, 32'h5A5A5A5A, rd, lows, ra, ro);
    n_chk++; if (lows != 3) begin n_fail++; $display("FAIL ws3_wr_lat got %0d want 3", lows); end
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    n_chk++; if (hro !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wait got %b want 0", hro); end
    rst = 1'b1; #1;
    n_chk++;
    if (hro !== 1'b1 || hresp !== 1'b0 || hrd !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_out ready=%b resp=%b data=%h want 1/0/0", hro, hresp, hrd);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 32'h40, 3'd2, 32'h0, rd, lows, ra, ro);
    n_chk++; if (rd !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL rst_mid_mem got %h want 5a5a5a5a", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_idle_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
